// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: expands valid/ready commands into register-file/ALU datapath cycles.
// Latency: LOAD = 2 write cycles, op = repeat+1 write cycles, then a 1-cycle DONE; ready again after DONE.
// Backpressure: cmd_ready high only in IDLE; no queue, cmd_valid outside IDLE is ignored.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready - command handshake; fields cmd_load, cmd_opcode, cmd_dst,
//                         cmd_src, cmd_imm, cmd_use_imm, cmd_repeat latched on accept
//   flags               - datapath flags (bit4 Z, bit3 C, bit1 L), captured into last_flags
//   regEnable, opCode, a_select, b_select, immediate, use_imm - datapath controls (Moore)
//   done                - one-cycle pulse at command completion
//   busy_abort          - only with `define ALU_SEQ_ABORT_EN: suppresses the current write
//                         and terminates the command through DONE
module alu_cmd_sequencer #(
    parameter int REPEAT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_load,
    input  logic [7:0]              cmd_opcode,
    input  logic [3:0]              cmd_dst,
    input  logic [3:0]              cmd_src,
    input  logic [15:0]             cmd_imm,
    input  logic                    cmd_use_imm,
    input  logic [REPEAT_WIDTH-1:0] cmd_repeat,
    input  logic [4:0]              flags,
`ifdef ALU_SEQ_ABORT_EN
    input  logic                    busy_abort,
`endif
    output logic [15:0]             regEnable,
    output logic [7:0]              opCode,
    output logic [3:0]              a_select,
    output logic [3:0]              b_select,
    output logic [15:0]             immediate,
    output logic                    use_imm,
    output logic                    done,
    output logic [4:0]              last_flags
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ORI  = 8'h20;
    localparam logic [7:0] OP_ANDI = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD1 = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q,     state_d;
    logic [7:0]              op_q,        op_d;
    logic [3:0]              dst_q,       dst_d;
    logic [3:0]              src_q,       src_d;
    logic [15:0]             imm_q,       imm_d;
    logic                    use_imm_q,   use_imm_d;
    logic [REPEAT_WIDTH-1:0] count_q,     count_d;
    logic [4:0]              last_flags_q, last_flags_d;

    logic        abort;
    logic        no_write_op;
    logic [15:0] dst_onehot;

`ifdef ALU_SEQ_ABORT_EN
    assign abort = busy_abort;
`else
    assign abort = 1'b0;
`endif

    assign dst_onehot = 16'h0001 << dst_q;

    // Compare-class ops and NOP only update flags; they must never write dst.
    always_comb begin
        no_write_op = 1'b0;
        case (op_q)
            8'h0B, 8'hB0, 8'h08, 8'h0C, OP_NOP: no_write_op = 1'b1;
            default:                            no_write_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        dst_d        = dst_q;
        src_d        = src_q;
        imm_d        = imm_q;
        use_imm_d    = use_imm_q;
        count_d      = count_q;
        last_flags_d = last_flags_q;

        cmd_ready    = 1'b0;
        regEnable    = 16'h0000;
        opCode       = OP_NOP;
        a_select     = 4'h0;
        b_select     = 4'h0;
        immediate    = 16'h0000;
        use_imm      = 1'b0;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    dst_d = cmd_dst;
                    imm_d = cmd_imm;
                    if (cmd_load) begin
                        op_d      = OP_ORI;
                        src_d     = 4'h0;
                        use_imm_d = 1'b1;
                        count_d   = '0;
                        state_d   = ST_LOAD1;
                    end else begin
                        op_d      = cmd_opcode;
                        src_d     = cmd_src;
                        use_imm_d = cmd_use_imm;
                        count_d   = cmd_repeat;
                        state_d   = ST_EXEC;
                    end
                end
            end

            // Load is ORI then ANDI with the same immediate: (dst|imm)&imm == imm,
            // so the old dst contents cannot leak through.
            ST_LOAD1: begin
                opCode    = op_q;
                a_select  = dst_q;
                b_select  = src_q;
                use_imm   = 1'b1;
                immediate = imm_q;
                regEnable = abort ? 16'h0000 : dst_onehot;
                if (abort) begin
                    state_d = ST_DONE;
                end else begin
                    op_d    = OP_ANDI;
                    count_d = '0;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                opCode    = op_q;
                a_select  = dst_q;
                b_select  = src_q;
                use_imm   = use_imm_q;
                immediate = imm_q;
                regEnable = (abort || no_write_op) ? 16'h0000 : dst_onehot;
                if (abort || (count_q == '0)) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - REPEAT_WIDTH'(1);
                end
            end

            ST_DONE: begin
                done         = 1'b1;
                last_flags_d = flags;
                state_d      = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NOP;
            dst_q        <= 4'h0;
            src_q        <= 4'h0;
            imm_q        <= 16'h0000;
            use_imm_q    <= 1'b0;
            count_q      <= '0;
            last_flags_q <= 5'h00;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            imm_q        <= imm_d;
            use_imm_q    <= use_imm_d;
            count_q      <= count_d;
            last_flags_q <= last_flags_d;
        end
    end

    assign last_flags = last_flags_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_load;
    logic [7:0]  cmd_opcode;
    logic [3:0]  cmd_dst;
    logic [3:0]  cmd_src;
    logic [15:0] cmd_imm;
    logic        cmd_use_imm;
    logic [3:0]  cmd_repeat;
    logic [4:0]  dp_flags;
`ifdef ALU_SEQ_ABORT_EN
    logic        busy_abort;
`endif
    logic [15:0] regEnable;
    logic [7:0]  opCode;
    logic [3:0]  a_select;
    logic [3:0]  b_select;
    logic [15:0] immediate;
    logic        use_imm;
    logic        done;
    logic [4:0]  last_flags;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.REPEAT_WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_load    (cmd_load),
        .cmd_opcode  (cmd_opcode),
        .cmd_dst     (cmd_dst),
        .cmd_src     (cmd_src),
        .cmd_imm     (cmd_imm),
        .cmd_use_imm (cmd_use_imm),
        .cmd_repeat  (cmd_repeat),
        .flags       (dp_flags),
`ifdef ALU_SEQ_ABORT_EN
        .busy_abort  (busy_abort),
`endif
        .regEnable   (regEnable),
        .opCode      (opCode),
        .a_select    (a_select),
        .b_select    (b_select),
        .immediate   (immediate),
        .use_imm     (use_imm),
        .done        (done),
        .last_flags  (last_flags)
    );

    // Small register-file/ALU model standing in for the datapath.
    logic [15:0] regs [16];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = 4'h0;
    logic [15:0] poke_val = 16'h0;
    logic [15:0] a_val, b_val, alu_res;
    logic [4:0]  alu_flg;
    logic [16:0] sum;

    always_comb begin
        a_val   = regs[a_select];
        b_val   = use_imm ? immediate : regs[b_select];
        sum     = {1'b0, a_val} + {1'b0, b_val};
        alu_res = 16'h0;
        alu_flg = 5'h0;
        case (opCode)
            8'h05, 8'h06: begin
                alu_res = sum[15:0];
                alu_flg = {(sum[15:0] == 16'h0), sum[16], 3'b000};
            end
            8'h20: begin
                alu_res = a_val | b_val;
                alu_flg = {(alu_res == 16'h0), 4'b0000};
            end
            8'h10: begin
                alu_res = a_val & b_val;
                alu_flg = {(alu_res == 16'h0), 4'b0000};
            end
            8'h0B: begin
                alu_res = a_val;
                alu_flg = {(a_val == b_val), 1'b0, 1'b0, ($signed(a_val) < $signed(b_val)), 1'b0};
            end
            default: begin
                alu_res = a_val;
                alu_flg = 5'h0;
            end
        endcase
    end

    always @(posedge clk) begin
        if (reset) dp_flags <= 5'h0;
        else if (opCode != 8'h00) dp_flags <= alu_flg;
        if (poke_en) begin
            regs[poke_idx] <= poke_val;
        end else begin
            for (int i = 0; i < 16; i++)
                if (regEnable[i]) regs[i] <= alu_res;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [15:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(negedge clk);
        poke_en  = 1'b0;
    endtask

    task automatic set_cmd(input logic ld, input logic [7:0] op, input logic [3:0] dst,
                           input logic [3:0] src, input logic [15:0] imm, input logic ui,
                           input logic [3:0] rep);
        cmd_load    = ld;
        cmd_opcode  = op;
        cmd_dst     = dst;
        cmd_src     = src;
        cmd_imm     = imm;
        cmd_use_imm = ui;
        cmd_repeat  = rep;
    endtask

    // Presents a command in an IDLE cycle; returns at the negedge of cycle N+1.
    task automatic issue(input logic ld, input logic [7:0] op, input logic [3:0] dst,
                         input logic [3:0] src, input logic [15:0] imm, input logic ui,
                         input logic [3:0] rep);
        @(negedge clk);
        set_cmd(ld, op, dst, src, imm, ui, rep);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Starting in cycle N+1, counts write cycles until done; returns in the cycle after done.
    task automatic run_to_done(input string tag, input int exp_writes, input int exp_cyc);
        int cyc    = 1;
        int writes = 0;
        bit seen   = 1'b0;
        while (cyc <= 40) begin
            if (regEnable != 16'h0) writes++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_writes"}, writes, exp_writes);
        check({tag, "_done_cycle"}, seen ? cyc : 0, exp_cyc);
        @(negedge clk);
        check({tag, "_ready_after"}, cmd_ready, 1);
        check({tag, "_done_low"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        set_cmd(1'b0, 8'h00, 4'h0, 4'h0, 16'h0, 1'b0, 4'h0);
`ifdef ALU_SEQ_ABORT_EN
        busy_abort = 1'b0;
`endif
        #1;
        check("rst_regEnable", regEnable, 16'h0);
        check("rst_opCode", opCode, 8'h00);
        check("rst_done", done, 0);
        check("rst_last_flags", last_flags, 5'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_dp", {a_select, b_select, immediate, use_imm}, 0);

        // LOAD r3 <- 0xBEEF over an old value of 0x1234
        poke(4'd3, 16'h1234);
        issue(1'b1, 8'hFF, 4'd3, 4'd9, 16'hBEEF, 1'b0, 4'd7);
        check("load_c1_regEnable", regEnable, 16'h0008);
        check("load_c1_opCode", opCode, 8'h20);
        check("load_c1_imm", {use_imm, immediate}, {1'b1, 16'hBEEF});
        check("load_c1_ready", cmd_ready, 0);
        @(negedge clk);
        check("load_c2_regEnable", regEnable, 16'h0008);
        check("load_c2_opCode", opCode, 8'h10);
        @(negedge clk);
        check("load_c3_done", done, 1);
        check("load_c3_regEnable", regEnable, 16'h0);
        check("load_c3_ready", cmd_ready, 0);
        @(negedge clk);
        check("load_c4_ready", cmd_ready, 1);
        check("load_r3", regs[3], 16'hBEEF);

        // ADD r4 = 5 + 3
        poke(4'd4, 16'd5);
        poke(4'd5, 16'd3);
        issue(1'b0, 8'h05, 4'd4, 4'd5, 16'h0, 1'b0, 4'd0);
        check("add_regEnable", regEnable, 16'h0010);
        check("add_sel", {a_select, b_select, opCode}, {4'd4, 4'd5, 8'h05});
        run_to_done("add", 1, 2);
        check("add_r4", regs[4], 16'd8);
        check("add_r5", regs[5], 16'd3);
        check("add_last_flags", last_flags, 5'h00);

        // ADDU r2,r2 repeated 3 times: 3 -> 6 -> 12 -> 24
        poke(4'd2, 16'd3);
        issue(1'b0, 8'h06, 4'd2, 4'd2, 16'h0, 1'b0, 4'd2);
        run_to_done("addu_rep2", 3, 4);
        check("addu_r2", regs[2], 16'h0018);

        // CMP r6,r7 equal: no write, Z captured
        poke(4'd6, 16'd7);
        poke(4'd7, 16'd7);
        issue(1'b0, 8'h0B, 4'd6, 4'd7, 16'h0, 1'b0, 4'd0);
        run_to_done("cmp", 0, 2);
        check("cmp_r6", regs[6], 16'd7);
        check("cmp_last_flags", last_flags, 5'h10);

        // Max repeat: 16 executions of r11 += r12
        poke(4'd11, 16'd0);
        poke(4'd12, 16'd1);
        issue(1'b0, 8'h05, 4'd11, 4'd12, 16'h0, 1'b0, 4'd15);
        run_to_done("rep_max", 16, 17);
        check("rep_max_r11", regs[11], 16'h0010);

        // Back-to-back with cmd_valid held: ADDU r8+=r9 x2, then ORI r8|0xF0
        poke(4'd8, 16'd1);
        poke(4'd9, 16'd2);
        poke(4'd6, 16'd7);
        issue(1'b0, 8'h0B, 4'd6, 4'd6, 16'h0, 1'b0, 4'd0);
        run_to_done("cmp2", 0, 2);
        @(negedge clk);
        set_cmd(1'b0, 8'h06, 4'd8, 4'd9, 16'h0, 1'b0, 4'd1);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        set_cmd(1'b0, 8'h20, 4'd8, 4'd0, 16'h00F0, 1'b1, 4'd0);
        check("b2b_c1_ready", cmd_ready, 0);
        check("b2b_c1_op", {opCode, a_select}, {8'h06, 4'd8});
        check("b2b_c1_flags_hold", last_flags, 5'h10);
        @(negedge clk);
        check("b2b_c2_ready", cmd_ready, 0);
        check("b2b_c2_op", opCode, 8'h06);
        check("b2b_c2_regEnable", regEnable, 16'h0100);
        @(negedge clk);
        check("b2b_c3_done", done, 1);
        check("b2b_c3_ready", cmd_ready, 0);
        @(negedge clk);
        check("b2b_c4_ready", cmd_ready, 1);
        check("b2b_c4_r8", regs[8], 16'd5);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_c5_op", {opCode, use_imm, immediate}, {8'h20, 1'b1, 16'h00F0});
        check("b2b_c5_regEnable", regEnable, 16'h0100);
        run_to_done("b2b_second", 1, 2);
        check("b2b_r8", regs[8], 16'h00F5);

        // Reset in the second EXEC cycle of repeat 5
        poke(4'd10, 16'd1);
        issue(1'b0, 8'h06, 4'd10, 4'd10, 16'h0, 1'b0, 4'd5);
        check("rstx_c1_regEnable", regEnable, 16'h0400);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstx_regEnable", regEnable, 16'h0);
        check("rstx_opCode", opCode, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstx_ready", cmd_ready, 1);
        check("rstx_done", done, 0);
        check("rstx_last_flags", last_flags, 5'h0);
        check("rstx_r10", regs[10], 16'd2);
        @(negedge clk);
        check("rstx_still_idle", {cmd_ready, regEnable}, {1'b1, 16'h0});

`ifdef ALU_SEQ_ABORT_EN
        poke(4'd10, 16'd1);
        issue(1'b0, 8'h06, 4'd10, 4'd10, 16'h0, 1'b0, 4'd5);
        @(negedge clk);
        busy_abort = 1'b1;
        #1;
        check("abort_regEnable", regEnable, 16'h0);
        @(negedge clk);
        busy_abort = 1'b0;
        check("abort_done", done, 1);
        @(negedge clk);
        check("abort_ready", cmd_ready, 1);
        check("abort_r10", regs[10], 16'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
